// File: rtl/adder_dft_pkg.sv
// adder_dft_pkg
// Shared constants and types for the adder output-side observe logic.
//   ADDER_W : default adder operand/sum width
//   FRAME_W : serial frame width, {cout,sum}
//   CNT_W   : bit-counter width able to hold 0..FRAME_W
//   obs_state_t : observe FSM states
package adder_dft_pkg;

  localparam int ADDER_W = 16;
  localparam int FRAME_W = ADDER_W + 1;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } obs_state_t;

endpackage

// File: rtl/piso_shreg.sv
// piso_shreg
// Parallel-load, serial-out shift register. Shifts right with zero fill,
// so the serial bit is always q[0].
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (highest priority)
//   load       : parallel load of din
//   shift      : shift right one position, zero fill at the MSB
//   din        : parallel load data
//   so         : serial output (current LSB)
module piso_shreg
  import adder_dft_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         so
);

  logic [W-1:0] q_r;

  // shift register storage with clear > load > shift priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= {W{1'b0}};
    end else if (clear) begin
      q_r <= {W{1'b0}};
    end else if (load) begin
      q_r <= din;
    end else if (shift) begin
      q_r <= {1'b0, q_r[W-1:1]};
    end else begin
      q_r <= q_r;
    end
  end

  assign so = q_r[0];

endmodule

// File: rtl/adder_test_observe.sv
// adder_test_observe
// Observes the adder result at the chip test pins. In functional mode
// (sel=0) sum/cout pass straight through. In test mode (sel=1) a capture
// request latches {cout,sum} and shifts it out LSB-first on pin_so, qualified
// by pin_so_vld, followed by a one-cycle done pulse.
// Optional build macro: ADDER_MISR_EN -- each accepted capture is folded into
// an (N+1)-bit rotate-XOR signature and the signature is shifted out instead
// of the raw frame.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   sel               : test-mode select (1 = test)
//   sum, cout         : adder core result
//   cap_req           : capture request, sampled every rising edge
//   sel_sum, sel_cout : functional outputs, zero in test mode (combinational)
//   pin_so, pin_so_vld: serial test data and its valid qualifier (flops)
//   busy              : high in SHIFT and DONE
//   done              : one-cycle pulse after the last frame bit
module adder_test_observe
  import adder_dft_pkg::*;
#(
  parameter int N = ADDER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sel,
  input  logic [N-1:0] sum,
  input  logic         cout,
  input  logic         cap_req,
  output logic [N-1:0] sel_sum,
  output logic         sel_cout,
  output logic         pin_so,
  output logic         pin_so_vld,
  output logic         busy,
  output logic         done
);

  localparam int FW = N + 1;
  localparam int CW = $clog2(FW + 1);

  obs_state_t    state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          pin_so_r, pin_so_nxt_s;
  logic          vld_r, vld_nxt_s;
  logic          busy_r, done_r;
  logic          load_s, shift_s, clear_s;
  logic          sh_so_s;
  logic [FW-1:0] frame_s;

  // Functional pass-through is gated off whenever test mode is selected.
  assign sel_sum  = sel ? {N{1'b0}} : sum;
  assign sel_cout = sel ? 1'b0 : cout;

`ifdef ADDER_MISR_EN
  logic [FW-1:0] sig_r;

  // Rotate the signature left by one, then fold in the new frame.
  function automatic logic [FW-1:0] misr_step(input logic [FW-1:0] sig,
                                              input logic [FW-1:0] data);
    misr_step = {sig[FW-2:0], sig[FW-1]} ^ data;
  endfunction

  assign frame_s = misr_step(sig_r, {cout, sum});

  // signature register, updated only on an accepted capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_r <= {FW{1'b0}};
    end else if (load_s) begin
      sig_r <= frame_s;
    end else begin
      sig_r <= sig_r;
    end
  end
`else
  assign frame_s = {cout, sum};
`endif

  // Bit 0 goes straight to the pin flop at the capture edge, so the shift
  // register holds the remaining bits and its LSB is always the next bit.
  piso_shreg #(
    .W (FW)
  ) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_s),
    .load  (load_s),
    .shift (shift_s),
    .din   ({1'b0, frame_s[FW-1:1]}),
    .so    (sh_so_s)
  );

  // next-state, shift-register control and next pin values
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    clear_s      = 1'b0;
    pin_so_nxt_s = 1'b0;
    vld_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel && cap_req) begin
          state_nxt_s  = SHIFT;
          load_s       = 1'b1;
          cnt_nxt_s    = {CW{1'b0}};
          pin_so_nxt_s = frame_s[0];
          vld_nxt_s    = 1'b1;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      SHIFT: begin
        if (!sel) begin
          // abort: drop the frame without a done pulse
          state_nxt_s = IDLE;
          clear_s     = 1'b1;
          cnt_nxt_s   = {CW{1'b0}};
        end else if (cnt_r == CW'(N)) begin
          state_nxt_s = DONE;
          clear_s     = 1'b1;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          state_nxt_s  = SHIFT;
          shift_s      = 1'b1;
          cnt_nxt_s    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          pin_so_nxt_s = sh_so_s;
          vld_nxt_s    = 1'b1;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        clear_s     = 1'b1;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // FSM state, counter and all pin-facing output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      pin_so_r <= 1'b0;
      vld_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      pin_so_r <= pin_so_nxt_s;
      vld_r    <= vld_nxt_s;
      busy_r   <= (state_nxt_s != IDLE);
      done_r   <= (state_nxt_s == DONE);
    end
  end

  assign pin_so     = pin_so_r;
  assign pin_so_vld = vld_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_adder_test_observe.sv
// tb_adder_test_observe
// Scoreboard bench: each capture pushes its expected serial bits to a queue,
// which is popped as valid bits appear on pin_so.
module tb_adder_test_observe;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [15:0] sum;
  logic        cout;
  logic        cap_req;
  logic [15:0] sel_sum;
  logic        sel_cout;
  logic        pin_so;
  logic        pin_so_vld;
  logic        busy;
  logic        done;

  int   errors = 0;
  int   checks = 0;
  logic exp_q[$];
  logic [16:0] sig_m;

  adder_test_observe #(.N(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel),
    .sum        (sum),
    .cout       (cout),
    .cap_req    (cap_req),
    .sel_sum    (sel_sum),
    .sel_cout   (sel_cout),
    .pin_so     (pin_so),
    .pin_so_vld (pin_so_vld),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle capture request and push the expected frame bits.
  // Called just after a negedge; returns at the negedge after the capture
  // edge, where bit 0 is already on the pin.
  task automatic start_capture(input logic [15:0] s, input logic c);
    logic [16:0] f;
    f = {c, s};
`ifdef ADDER_MISR_EN
    sig_m = {sig_m[15:0], sig_m[16]} ^ f;
    f = sig_m;
`endif
    for (int i = 0; i < 17; i++) exp_q.push_back(f[i]);
    sel = 1'b1; sum = s; cout = c; cap_req = 1'b1;
    @(negedge clk);
    cap_req = 1'b0;
  endtask

  // Follow one full frame plus done and return-to-idle. At cycle poke_at a
  // stray capture request is made and sum/cout are cleared.
  task automatic drain_frame(input string tag, input int poke_at);
    logic [3:0] obs;
    logic [3:0] exp;
    logic       b;
    for (int cyc = 0; cyc < 19; cyc++) begin
      if (cyc > 0) @(negedge clk);
      obs = {pin_so_vld, pin_so, busy, done};
      if (cyc < 17) begin
        b = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        exp = {1'b1, b, 1'b1, 1'b0};
      end else if (cyc == 17) begin
        exp = 4'b0011;
      end else begin
        exp = 4'b0000;
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s cyc%0d {vld,so,busy,done} got=%b exp=%b", tag, cyc, obs, exp);
      end
      checks++;
      if ({sel_sum, sel_cout} !== 17'h0) begin
        errors++;
        $display("FAIL %s cyc%0d sel_sum/cout got=%h/%b exp=0/0", tag, cyc, sel_sum, sel_cout);
      end
      if (cyc == poke_at) begin
        cap_req = 1'b1; sum = 16'h0000; cout = 1'b0;
      end else begin
        cap_req = 1'b0;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover got=%0d exp=0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sig_m = 17'h0;
    for (int i = 0; i < 4; i++) begin
      sel = 1'($urandom); sum = 16'($urandom); cout = 1'($urandom);
      cap_req = 1'($urandom);
      #3;
      checks++;
      if ({pin_so, pin_so_vld, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset got=%b exp=0000", {pin_so, pin_so_vld, busy, done});
      end
      @(negedge clk);
    end
    sel = 1'b0; cap_req = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({pin_so, pin_so_vld, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset got=%b exp=0000", {pin_so, pin_so_vld, busy, done});
    end
  endtask

  task automatic test_passthrough;
    sel = 1'b0; sum = 16'h1234; cout = 1'b1; cap_req = 1'b1;
    #1;
    checks++;
    if ({sel_cout, sel_sum} !== 17'h1_1234) begin
      errors++;
      $display("FAIL passthru got=%h exp=11234", {sel_cout, sel_sum});
    end
    @(negedge clk);
    cap_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy, pin_so_vld, done} !== 3'b000) begin
        errors++;
        $display("FAIL passthru_idle cyc%0d got=%b exp=000", i, {busy, pin_so_vld, done});
      end
      @(negedge clk);
    end
    sel = 1'b1; #1;
    checks++;
    if ({sel_cout, sel_sum} !== 17'h0) begin
      errors++;
      $display("FAIL testmode_gate got=%h exp=0", {sel_cout, sel_sum});
    end
  endtask

  task automatic test_normal_frame;
    start_capture(16'hA5A5, 1'b1);
    drain_frame("normal", -1);
  endtask

  task automatic test_ignored_request;
    start_capture(16'hA5A5, 1'b1);
    drain_frame("ignored", 3);
  endtask

  task automatic test_back_to_back;
    start_capture(16'h8001, 1'b0);
    drain_frame("b2b_a", -1);
    start_capture(16'h7FFE, 1'b1);
    drain_frame("b2b_b", -1);
  endtask

  task automatic test_abort;
    logic b;
    start_capture(16'h3C5A, 1'b0);
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc > 0) @(negedge clk);
      b = exp_q.pop_front();
      checks++;
      if ({pin_so_vld, pin_so, busy, done} !== {1'b1, b, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL abort_pre cyc%0d got=%b exp=%b", cyc,
                 {pin_so_vld, pin_so, busy, done}, {1'b1, b, 1'b1, 1'b0});
      end
    end
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({pin_so_vld, pin_so, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL abort_post cyc%0d got=%b exp=0000", i,
                 {pin_so_vld, pin_so, busy, done});
      end
    end
    exp_q.delete();
    start_capture(16'hF00F, 1'b1);
    drain_frame("recover", -1);
  endtask

`ifdef ADDER_MISR_EN
  task automatic test_misr;
    logic [16:0] k;
    rst_n = 1'b0; sig_m = 17'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_capture(16'h0001, 1'b0);
    exp_q.delete();
    k = 17'h00001;
    for (int i = 0; i < 17; i++) exp_q.push_back(k[i]);
    drain_frame("misr1", -1);
    start_capture(16'h0001, 1'b0);
    exp_q.delete();
    k = 17'h00003;
    for (int i = 0; i < 17; i++) exp_q.push_back(k[i]);
    drain_frame("misr2", -1);
  endtask
`endif

  initial begin
    sel = 1'b0; sum = 16'h0; cout = 1'b0; cap_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_normal_frame();
    test_ignored_request();
    test_back_to_back();
    test_abort();
`ifdef ADDER_MISR_EN
    test_misr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
